// File: rtl/button_event.sv
// button_event: turns a debounced button level into one-cycle UI strobes.
// Auto-repeat while held is built only when BUTTON_AUTO_REPEAT_EN is defined.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   clean      debounced level, synchronous to clk, 1 = pressed
//   pressed    registered copy of clean
//   press      strobe: button went down
//   release_ev strobe: button went up
//   click      strobe: single short click confirmed
//   dclick     strobe: second press inside the double-click window
//   long_press strobe: hold reached LONG_CYCLES
//   repeat_ev  strobe: auto-repeat while held (0 without the macro)
module button_event #(
    parameter int CBITS         = 26,
    parameter int LONG_CYCLES   = 32500000,
    parameter int REPEAT_CYCLES = 6500000,
    parameter int DCLICK_CYCLES = 19500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clean,
    output logic pressed,
    output logic press,
    output logic release_ev,
    output logic click,
    output logic dclick,
    output logic long_press,
    output logic repeat_ev
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD,
        WAIT_SECOND
    } state_t;

    localparam logic [CBITS-1:0] LONG_M1 = CBITS'(LONG_CYCLES - 1);
    localparam logic [CBITS-1:0] DCLK_M1 = CBITS'(DCLICK_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CBITS-1:0] REP_M1  = CBITS'(REPEAT_CYCLES - 1);
`endif

    state_t           state, state_n;
    logic [CBITS-1:0] count, count_n;
    logic             second, second_n;
    // A level already high at reset release is not a press; wait for a low.
    logic             armed;
    logic             rise, fall;
    logic             press_n, release_n, click_n;
    logic             dclick_n, long_n, repeat_n;

    assign rise = clean & ~pressed;
    assign fall = ~clean & pressed;

    // State register and registered strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            second     <= 1'b0;
            armed      <= 1'b0;
            pressed    <= 1'b0;
            press      <= 1'b0;
            release_ev <= 1'b0;
            click      <= 1'b0;
            dclick     <= 1'b0;
            long_press <= 1'b0;
            repeat_ev  <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            second     <= second_n;
            armed      <= armed | ~clean;
            pressed    <= clean;
            press      <= press_n;
            release_ev <= release_n;
            click      <= click_n;
            dclick     <= dclick_n;
            long_press <= long_n;
            repeat_ev  <= repeat_n;
        end
    end

    // Next-state and interval counter
    always_comb begin
        state_n  = state;
        count_n  = count + 1'b1;
        second_n = second;
        unique case (state)
            IDLE: begin
                count_n = '0;
                if (rise && armed) begin
                    state_n  = PRESSED;
                    second_n = 1'b0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_n = second ? IDLE : WAIT_SECOND;
                    count_n = '0;
                end else if (count == LONG_M1) begin
                    state_n = HELD;
                    count_n = '0;
                end
            end
            HELD: begin
                if (fall) begin
                    state_n = IDLE;
                    count_n = '0;
                end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (count == REP_M1)
                        count_n = '0;
`else
                    count_n = '0;
`endif
                end
            end
            WAIT_SECOND: begin
                if (rise) begin
                    state_n  = PRESSED;
                    second_n = 1'b1;
                    count_n  = '0;
                end else if (count == DCLK_M1) begin
                    state_n = IDLE;
                    count_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // Strobe decode, registered in the state process
    always_comb begin
        press_n   = 1'b0;
        release_n = 1'b0;
        click_n   = 1'b0;
        dclick_n  = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        unique case (state)
            IDLE: begin
                press_n = rise & armed;
            end
            PRESSED: begin
                if (fall)
                    release_n = 1'b1;
                else if (count == LONG_M1)
                    long_n = 1'b1;
            end
            HELD: begin
                if (fall)
                    release_n = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (count == REP_M1)
                    repeat_n = 1'b1;
`endif
            end
            WAIT_SECOND: begin
                if (rise) begin
                    press_n  = 1'b1;
                    dclick_n = 1'b1;
                end else if (count == DCLK_M1) begin
                    click_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed and random button traces against a
// timestamp-based reference model of the button event rules.
module tb_button_event;

    localparam int LONG   = 10;
    localparam int REPEAT = 4;
    localparam int DCLICK = 6;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clean = 1'b0;
    logic pressed, press, release_ev, click;
    logic dclick, long_press, repeat_ev;

    int errors = 0;
    int checks = 0;

    button_event #(
        .CBITS(8),
        .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REPEAT),
        .DCLICK_CYCLES(DCLICK)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clean(clean),
        .pressed(pressed),
        .press(press),
        .release_ev(release_ev),
        .click(click),
        .dclick(dclick),
        .long_press(long_press),
        .repeat_ev(repeat_ev)
    );

    always #5 clk = ~clk;

    // Reference model: timestamps of press / release / last hold event
    int t = 0;
    bit prev, armed, down, second, long_fired, waiting;
    int t_down, t_last, t_rel;
    bit e_pressed, e_press, e_rel, e_click;
    bit e_dclick, e_long, e_rep;

    task automatic model_reset();
        prev = 0; armed = 0; down = 0; second = 0;
        long_fired = 0; waiting = 0;
    endtask

    task automatic model_edge(input bit c);
        bit r, f;
        t++;
        e_pressed = c;
        e_press = 0; e_rel = 0; e_click = 0;
        e_dclick = 0; e_long = 0; e_rep = 0;
        r = c & !prev;
        f = !c & prev;
        if (!armed) begin
            if (!c) armed = 1;
        end else if (down) begin
            if (f) begin
                e_rel = 1;
                down = 0;
                if (!second && !long_fired) begin
                    waiting = 1;
                    t_rel = t;
                end
            end else if (!long_fired && t - t_down == LONG) begin
                e_long = 1;
                long_fired = 1;
                t_last = t;
            end else if (long_fired && AUTO && t - t_last == REPEAT) begin
                e_rep = 1;
                t_last = t;
            end
        end else if (waiting) begin
            if (r) begin
                e_press = 1; e_dclick = 1;
                down = 1; second = 1; long_fired = 0;
                t_down = t; waiting = 0;
            end else if (t - t_rel == DCLICK) begin
                e_click = 1;
                waiting = 0;
            end
        end else if (r) begin
            e_press = 1;
            down = 1; second = 0; long_fired = 0;
            t_down = t;
        end
        prev = c;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pressed", pressed, e_pressed);
        chk("press", press, e_press);
        chk("release", release_ev, e_rel);
        chk("click", click, e_click);
        chk("dclick", dclick, e_dclick);
        chk("long_press", long_press, e_long);
        chk("repeat", repeat_ev, e_rep);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pressed"}, pressed, 1'b0);
        chk({tag, "_press"}, press, 1'b0);
        chk({tag, "_release"}, release_ev, 1'b0);
        chk({tag, "_click"}, click, 1'b0);
        chk({tag, "_dclick"}, dclick, 1'b0);
        chk({tag, "_long"}, long_press, 1'b0);
        chk({tag, "_repeat"}, repeat_ev, 1'b0);
    endtask

    task automatic step(input bit c);
        clean = c;
        @(posedge clk);
        model_edge(c);
        #1;
        check_all();
    endtask

    task automatic hold(input bit c, input int n);
        for (int i = 0; i < n; i++) step(c);
    endtask

    // Asynchronous reset mid-activity; clean keeps its current value.
    task automatic do_reset(input string tag);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero(tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit lvl;
        model_reset();
        #2;
        check_zero("por");
        @(negedge clk);
        reset_n = 1'b1;
        hold(0, 10);

        // short click
        hold(1, 3); hold(0, 12);
        // double click
        hold(1, 3); hold(0, 2); hold(1, 3); hold(0, 12);
        // long hold with repeats
        hold(1, 25); hold(0, 12);
        // release on the long-press compare cycle, then click
        hold(1, LONG); hold(0, 12);
        // second press exactly on the click timeout cycle
        hold(1, 3); hold(0, DCLICK); hold(1, 3); hold(0, 12);
        // long press after a double click
        hold(1, 2); hold(0, 3); hold(1, 20); hold(0, 12);

        // reset while HELD, clean held high through release
        hold(1, 15);
        do_reset("rst_held");
        hold(1, 5); hold(0, 3); hold(1, 3); hold(0, 12);

        // reset while WAIT_SECOND, clean high through release
        hold(1, 3); hold(0, 2);
        clean = 1'b1;
        do_reset("rst_wait");
        hold(1, 4); hold(0, 2); hold(1, 3); hold(0, 12);

        // random traces
        lvl = 1'b0;
        for (int k = 0; k < 120; k++) begin
            lvl = ~lvl;
            hold(lvl, $urandom_range(1, 14));
            if ($urandom_range(0, 19) == 0) do_reset("rst_rand");
        end
        hold(0, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the pushbutton debouncer and consumes its clean, already-synchronous level output.
- Turns that level into single-cycle user-interface events: press, release, single click, double click, long press, and optional auto-repeat while held.
- All outputs are registered one-cycle strobes, except the `pressed` level.
- Intended to drive menu and control FSMs directly, with no further conditioning.

Parameters:
- CBITS, 26, width of the shared interval counter; every *_CYCLES value must be < 2^CBITS.
- LONG_CYCLES, 32500000, cycles held before long_press fires (0.5 s at 65 MHz).
- REPEAT_CYCLES, 6500000, cycles between repeat strobes while held (0.1 s at 65 MHz).
- DCLICK_CYCLES, 19500000, window after a short release in which a second press counts as a double click (0.3 s).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clean  in  1  debounced button level, synchronous to clk, 1 = pressed.
- pressed  out  1  registered copy of clean.
- press  out  1  one-cycle strobe on press.
- release  out  1  one-cycle strobe on release.
- click  out  1  one-cycle strobe: single short click confirmed.
- dclick  out  1  one-cycle strobe: double click.
- long_press  out  1  one-cycle strobe: hold reached LONG_CYCLES.
- repeat  out  1  one-cycle strobe: auto-repeat while held.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, count=0, second=0.
  - pressed and all strobes = 0.
  - Takes effect immediately, including mid-hold or mid-window.
  - No events are generated at reset release, even if clean=1. The press must first be released and pressed again.
- Edge detection:
  - rise = clean & ~pressed; fall = ~clean & pressed.
  - pressed <= clean every edge.
  - press/release are registered: they are high for exactly the one cycle after the edge at which rise/fall is evaluated.
- Strobes:
  - All strobes default to 0 each cycle.
  - At most press+dclick may coincide.
  - No other two strobes are ever high in the same cycle.
- Counter:
  - count saturates at nothing.
  - It is cleared on every state transition and on every repeat strobe.
  - Compares use count == X-1.
- States:
  - IDLE:
    - rise -> press, PRESSED, second=0.
  - PRESSED:
    - fall -> release.
      - If second=0, go to WAIT_SECOND.
      - If second=1, go to IDLE.
    - count==LONG_CYCLES-1 with clean still 1 -> long_press, go to HELD.
    - fall takes priority over the long-press compare in the same cycle.
  - HELD:
    - fall -> release, go to IDLE. No click is generated.
    - count==REPEAT_CYCLES-1 -> repeat, count=0 (see optional feature).
    - First repeat occurs REPEAT_CYCLES after long_press.
  - WAIT_SECOND:
    - rise -> press+dclick in the same cycle, go to PRESSED with second=1.
    - count==DCLICK_CYCLES-1 -> click, go to IDLE.
    - rise takes priority over timeout in the same cycle.
- Long press after a double click:
  - A second press held to LONG_CYCLES still gives long_press/HELD.
  - Its release never produces click.
- Spurious level in IDLE:
  - clean high without a preceding rise (only possible right after reset) is ignored until a fall is seen.
- Latency:
  - press/release: 1 cycle after clean changes is sampled.
  - click: exactly DCLICK_CYCLES cycles after release.

Optional Feature:
- BUTTON_AUTO_REPEAT_EN.
  - Defined: HELD generates a repeat strobe every REPEAT_CYCLES, as described under Behaviour.
  - Undefined:
    - repeat is tied to 0.
    - The HELD counter is frozen at 0.
    - HELD only waits for fall.
    - REPEAT_CYCLES is unused.

Test Plan (CBITS=8, LONG=10, REPEAT=4, DCLICK=6, macro defined):
- Press for 3 cycles, then release -> press at +1.
  - release 1 cycle after fall.
  - click exactly 6 cycles after release.
  - No dclick or long_press.
- Press 3, release 2, press 3, release -> second press gives press+dclick in the same cycle.
  - Second release goes to IDLE.
  - click never fires.
- Hold 25 cycles -> long_press 10 cycles after press.
  - repeat at +4 and +8 after it (and so on every 4).
  - release on fall, with no click.
- Release exactly on the long-press compare cycle -> release only, no long_press, then click after 6 cycles.
  - Second press on the DCLICK timeout cycle -> dclick, no click.
- Assert reset_n low while in HELD and while in WAIT_SECOND, with clean=1 held through reset release -> all outputs 0 immediately.
  - No press until clean falls and rises again.
  - Rerun with the macro undefined: hold 25 cycles -> long_press only, repeat stays 0.
